// File: rtl/vx_fpbf16_cvt_if.sv
// FPU rounding-mode and exception-flag definitions, plus the request/response bundle of the BF16 converter.
// master = requester side, slave = converter side.
package vx_fpbf16_pkg;
  localparam int INST_FRM_BITS = 3;
  localparam logic [INST_FRM_BITS-1:0] FRM_RNE = 3'd0;
  localparam logic [INST_FRM_BITS-1:0] FRM_RTZ = 3'd1;
  localparam logic [INST_FRM_BITS-1:0] FRM_RDN = 3'd2;
  localparam logic [INST_FRM_BITS-1:0] FRM_RUP = 3'd3;
  localparam logic [INST_FRM_BITS-1:0] FRM_RMM = 3'd4;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;
endpackage

interface vx_fpbf16_cvt_if #(
  parameter int TAGW  = 1,
  parameter int LANES = 1
);
  logic                                       valid_in;
  logic                                       ready_in;
  logic [TAGW-1:0]                            tag_in;
  logic [vx_fpbf16_pkg::INST_FRM_BITS-1:0]    frm;
  logic                                       is_narrow;
  logic [LANES-1:0][31:0]                     dataa;
  logic [LANES-1:0][31:0]                     result;
  logic                                       has_fflags;
  vx_fpbf16_pkg::fflags_t [LANES-1:0]         fflags;
  logic [TAGW-1:0]                            tag_out;
  logic                                       valid_out;
  logic                                       ready_out;

  modport master (
    output valid_in, tag_in, frm, is_narrow, dataa, ready_out,
    input  ready_in, result, has_fflags, fflags, tag_out, valid_out
  );

  modport slave (
    input  valid_in, tag_in, frm, is_narrow, dataa, ready_out,
    output ready_in, result, has_fflags, fflags, tag_out, valid_out
  );
endinterface

// File: rtl/vx_fpbf16_cvt.sv
// Multi-lane FP32<->BF16 converter, LATENCY cycles, 1/cycle; the whole pipe freezes while the output is held.
// FPU_BF16_NAN_PAYLOAD_EN keeps quieted NaN sign/payload instead of the canonical NaN.
module vx_fpbf16_cvt #(
  parameter int TAGW    = 1,
  parameter int LANES   = 1,
  parameter int LATENCY = 2
) (
  input logic          clk,
  input logic          reset,
  vx_fpbf16_cvt_if.slave io
);
  import vx_fpbf16_pkg::*;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
    logic       inc;
    logic       nan;
    logic       inf;
    logic       zero;
    logic       nv;
    logic       uf;
    logic       nx;
  } lane_t;

  typedef struct packed {
    logic                     vld;
    logic [TAGW-1:0]          tag;
    logic                     narrow;
    logic [INST_FRM_BITS-1:0] frm;
    lane_t [LANES-1:0]        lane;
  } stage_t;

  typedef struct packed {
    logic [31:0] val;
    fflags_t     fl;
  } res_t;

  function automatic lane_t decode(input logic [31:0] x, input logic narrow,
                                   input logic [INST_FRM_BITS-1:0] rm);
    lane_t       d;
    logic [22:0] frac;
    logic        guard, sticky, rne;
    d      = '0;
    d.sign = x[31];
    d.exp  = x[30:23];
    d.man  = x[22:16];
    // Widen only looks at the BF16 half, so its NaN test ignores the low mantissa bits.
    frac   = narrow ? x[22:0] : {x[22:16], 16'h0};
    guard  = x[15];
    sticky = |x[14:0];
    rne    = guard & (sticky | x[16]);
    d.nan  = (d.exp == 8'hFF) && (frac != '0);
    d.inf  = (d.exp == 8'hFF) && (frac == '0);
    d.zero = (d.exp == 8'h00);
    if (narrow) begin
      d.nv = d.nan & ~x[22];
      if (d.zero && (frac != '0)) begin
        d.uf = 1'b1;
        d.nx = 1'b1;
      end
      if (!d.zero && (d.exp != 8'hFF)) begin
        d.nx = guard | sticky;
        case (rm)
          FRM_RNE: d.inc = rne;
          FRM_RTZ: d.inc = 1'b0;
          FRM_RDN: d.inc = d.sign & d.nx;
          FRM_RUP: d.inc = ~d.sign & d.nx;
          FRM_RMM: d.inc = guard;
          default: d.inc = rne;
        endcase
      end
    end
    return d;
  endfunction

  function automatic res_t pack(input lane_t d, input logic [INST_FRM_BITS-1:0] rm);
    res_t        r;
    logic [14:0] sum;
    logic [31:0] inf_v, max_v;
    r      = '0;
    r.fl.nv = d.nv;
    r.fl.uf = d.uf;
    r.fl.nx = d.nx;
    // The mantissa carry ripples straight into the exponent field.
    sum    = {d.exp, d.man} + 15'(d.inc);
    inf_v  = {d.sign, 8'hFF, 23'h0};
    max_v  = {d.sign, 8'hFE, 7'h7F, 16'h0};
    if (d.nan) begin
`ifdef FPU_BF16_NAN_PAYLOAD_EN
      r.val = {d.sign, 8'hFF, 1'b1, d.man[5:0], 16'h0};
`else
      r.val = 32'h7FC0_0000;
`endif
    end else if (d.inf) begin
      r.val = inf_v;
    end else if (d.zero) begin
      r.val = {d.sign, 31'h0};
    end else if (sum[14:7] == 8'hFF) begin
      r.fl.of = 1'b1;
      r.fl.nx = 1'b1;
      case (rm)
        FRM_RTZ: r.val = max_v;
        FRM_RDN: r.val = d.sign ? inf_v : max_v;
        FRM_RUP: r.val = d.sign ? max_v : inf_v;
        default: r.val = inf_v;
      endcase
    end else begin
      r.val = {d.sign, sum, 16'h0};
    end
    return r;
  endfunction

  stage_t            in_stage;
  stage_t            last;
  stage_t            pipe [LATENCY-1];
  res_t [LANES-1:0]  pk;
  logic              enable;

  assign enable      = ~(io.valid_out & ~io.ready_out);
  assign io.ready_in = enable;
  assign last        = pipe[LATENCY-2];

  always_comb begin
    in_stage        = '0;
    in_stage.vld    = io.valid_in;
    in_stage.tag    = io.tag_in;
    in_stage.narrow = io.is_narrow;
    in_stage.frm    = io.frm;
    for (int i = 0; i < LANES; i++) begin
      in_stage.lane[i] = decode(io.dataa[i], io.is_narrow, io.frm);
    end
  end

  always_comb begin
    pk = '0;
    for (int i = 0; i < LANES; i++) begin
      pk[i] = pack(last.lane[i], last.frm);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY-1; i++) pipe[i] <= '0;
      io.valid_out  <= 1'b0;
      io.result     <= '0;
      io.fflags     <= '0;
      io.has_fflags <= 1'b0;
      io.tag_out    <= '0;
    end else if (enable) begin
      pipe[0] <= in_stage;
      for (int i = 1; i < LATENCY-1; i++) pipe[i] <= pipe[i-1];
      io.valid_out  <= last.vld;
      io.tag_out    <= last.tag;
      io.has_fflags <= last.narrow;
      for (int i = 0; i < LANES; i++) begin
        io.result[i] <= pk[i].val;
        io.fflags[i] <= pk[i].fl;
      end
    end
  end
endmodule
